seg_display_reader: RTL

- Receiver end of the multiplexed 7-segment display bus: watches the active-low anode strobes and active-low cathode pattern, and reconstructs the BCD value shown on each digit.
- Used as an on-chip monitor and loopback checker for the display path, and as a bench-side observer.
- Captures a pattern only after it has been stable for a settling window, so ghosting during scan transitions is never captured.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_pattern_to_bcd.sv | 36 +++
 rtl/seg_display_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment display path.
// Segment patterns are active-low, ordered abcdefg (bit6 = a ... bit0 = g).
package seg_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Combinational lookup from an active-low segment pattern to a BCD digit.
// hit = pattern is one of 0..9, blank = all segments off.
module seg_pattern_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0]       pattern,
    output logic             hit,
    output logic             blank,
    output logic [BCD_W-1:0] value
);

    // Table lookup; anything unrecognised reports neither hit nor blank.
    always_comb begin
        hit   = 1'b1;
        blank = 1'b0;
        value = '0;
        case (pattern)
            SEG_0:     value = BCD_W'(0);
            SEG_1:     value = BCD_W'(1);
            SEG_2:     value = BCD_W'(2);
            SEG_3:     value = BCD_W'(3);
            SEG_4:     value = BCD_W'(4);
            SEG_5:     value = BCD_W'(5);
            SEG_6:     value = BCD_W'(6);
            SEG_7:     value = BCD_W'(7);
            SEG_8:     value = BCD_W'(8);
            SEG_9:     value = BCD_W'(9);
            SEG_BLANK: begin
                hit   = 1'b0;
                blank = 1'b1;
            end
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_display_reader.sv
// Receiver for a multiplexed 7-segment bus: waits for each (anode, cathode)
// pair to settle, then decodes it into the per-digit BCD store.
// Optional frame tracking (frame_done / frame_count) is enabled by defining
// SEG_READER_FRAME_EN.
module seg_display_reader
    import seg_pkg::*;
#(
    parameter  int NUM_DIGITS    = 4,
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_DIGITS-1:0]       anode,
    input  logic [6:0]                  cathode,
    input  logic                        clear,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]       digit_valid,
    output logic                        update,
    output logic                        pattern_err,
    output logic                        anode_err
`ifdef SEG_READER_FRAME_EN
    ,
    output logic                        frame_done,
    output logic [15:0]                 frame_count
`endif
);

    logic [NUM_DIGITS-1:0]       anode_reg, anode_prev_reg;
    logic [6:0]                  cathode_reg, cathode_prev_reg;
    state_t                      state_reg, state_next;
    logic [CNT_W-1:0]            cnt_reg, cnt_next;
    logic                        changed, none_low, multi_low;
    logic                        capture, capture_single, capture_multi;
    logic [NUM_DIGITS-1:0]       low;
    logic                        dec_hit, dec_blank;
    logic [BCD_W-1:0]            dec_value;
    logic [BCD_W*NUM_DIGITS-1:0] digits_reg, digits_next;
    logic [NUM_DIGITS-1:0]       valid_reg, valid_next, wr_sel;
    logic                        update_reg, pattern_err_reg, anode_err_reg;

    // Input registration plus one-cycle history for change detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_reg        <= '1;
            anode_prev_reg   <= '1;
            cathode_reg      <= '1;
            cathode_prev_reg <= '1;
        end else begin
            anode_reg        <= anode;
            anode_prev_reg   <= anode_reg;
            cathode_reg      <= cathode;
            cathode_prev_reg <= cathode_reg;
        end
    end

    assign changed   = (anode_reg != anode_prev_reg) || (cathode_reg != cathode_prev_reg);
    assign low       = ~anode_reg;
    assign none_low  = (low == '0);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_low = |(low & (low - NUM_DIGITS'(1)));

    seg_pattern_to_bcd u_dec (
        .pattern (cathode_reg),
        .hit     (dec_hit),
        .blank   (dec_blank),
        .value   (dec_value)
    );

    // FSM state and settle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Any change restarts settling; a full stable window in SETTLE captures once.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        if (changed) begin
            state_next = none_low ? IDLE : SETTLE;
            cnt_next   = '0;
        end else if (state_reg == SETTLE) begin
            if (cnt_reg == CNT_W'(STABLE_CYCLES - 1)) begin
                capture    = 1'b1;
                state_next = HOLD;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    assign capture_single = capture && !multi_low;
    assign capture_multi  = capture && multi_low;

    // Per-digit next values: a capture owns its digit's valid bit even under clear.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign wr_sel[gi] = capture_single && low[gi];
            assign digits_next[gi*BCD_W +: BCD_W] =
                (wr_sel[gi] && dec_hit) ? dec_value : digits_reg[gi*BCD_W +: BCD_W];
            assign valid_next[gi] = wr_sel[gi] ? dec_hit : (clear ? 1'b0 : valid_reg[gi]);
        end
    endgenerate

    // Output store, update strobe and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_reg      <= '0;
            valid_reg       <= '0;
            update_reg      <= 1'b0;
            pattern_err_reg <= 1'b0;
            anode_err_reg   <= 1'b0;
        end else begin
            digits_reg <= digits_next;
            valid_reg  <= valid_next;
            update_reg <= capture;
            if (capture_single && !dec_hit && !dec_blank)
                pattern_err_reg <= 1'b1;
            else if (clear)
                pattern_err_reg <= 1'b0;
            if (capture_multi)
                anode_err_reg <= 1'b1;
            else if (clear)
                anode_err_reg <= 1'b0;
        end
    end

    assign digits      = digits_reg;
    assign digit_valid = valid_reg;
    assign update      = update_reg;
    assign pattern_err = pattern_err_reg;
    assign anode_err   = anode_err_reg;

`ifdef SEG_READER_FRAME_EN
    logic [NUM_DIGITS-1:0] seen_reg, seen_next;
    logic [15:0]           frame_count_reg;
    logic                  frame_done_reg;

    assign seen_next = seen_reg | (capture_single ? low : '0);

    // A frame completes once every digit index has been captured at least once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_reg        <= '0;
            frame_count_reg <= '0;
            frame_done_reg  <= 1'b0;
        end else if (clear) begin
            seen_reg        <= '0;
            frame_count_reg <= '0;
            frame_done_reg  <= 1'b0;
        end else if (&seen_next) begin
            seen_reg        <= '0;
            frame_count_reg <= frame_count_reg + 16'd1;
            frame_done_reg  <= 1'b1;
        end else begin
            seen_reg       <= seen_next;
            frame_done_reg <= 1'b0;
        end
    end

    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;
`endif

endmodule
